// File: rtl/free_list.sv
// ----------------------------------------------------------------------------
// free_list
//
// Physical-register free list for the rename stage. A one-bit-per-register
// bitmask (free_mask, bit i = 1 means register i is free) tracks which
// physical registers are free. Each allocation request takes the
// lowest-numbered free register. Commit/recovery logic can release one
// register per cycle.
//
// Request/response semantics: alloc_en is a single-cycle request with no
// back-pressure. The edge that samples alloc_en also loads alloc_phys and
// alloc_valid, so the result can be read just after that edge.
// alloc_valid = 1 means the request got a register. alloc_valid = 0 means the
// list was empty. Both outputs hold their value until the next request, so
// alloc_valid reports the status of the last request and is not a per-cycle
// strobe.
//
// Ports:
//   clk          system clock; all state changes on the rising edge
//   reset        synchronous, active-high; every register becomes free
//   alloc_en     request one register allocation this cycle
//   alloc_phys   index of the most recently granted register (registered)
//   alloc_valid  the most recent allocation request succeeded (registered)
//   free_en      release register free_phys this cycle
//   free_phys    index of the register being released; indices at or above
//                PHYS_REGS are ignored
// ----------------------------------------------------------------------------
module free_list #(
    parameter int PHYS_REGS = 64    // legal range 2..64 (6-bit index ports)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alloc_en,
    output logic [5:0] alloc_phys,
    output logic       alloc_valid,
    input  logic       free_en,
    input  logic [5:0] free_phys
);

    logic [PHYS_REGS-1:0] free_mask;
    logic [PHYS_REGS-1:0] next_mask;
    logic [5:0]           grant_idx;
    logic                 grant_found;
    logic                 free_ok;

    // Lowest-index priority encoder over the pre-edge mask. The loop scans
    // downward, so the last match written is the lowest free index.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = PHYS_REGS - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                grant_found = 1'b1;
                grant_idx   = 6'(i);
            end
        end
    end

    // Zero-extend before the compare so PHYS_REGS = 64 still compares cleanly.
    assign free_ok = free_en && ({1'b0, free_phys} < 7'(PHYS_REGS));

    // The grant clears its bit first and the free then sets its bit. If both
    // hit the same index, the free wins and the register stays free.
    always_comb begin
        next_mask = free_mask;
        for (int i = 0; i < PHYS_REGS; i++) begin
            if (alloc_en && grant_found && (grant_idx == 6'(i))) begin
                next_mask[i] = 1'b0;
            end
            if (free_ok && (free_phys == 6'(i))) begin
                next_mask[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            free_mask   <= '1;
            alloc_phys  <= '0;
            alloc_valid <= 1'b0;
        end else begin
            free_mask <= next_mask;
            if (alloc_en) begin
                alloc_phys  <= grant_found ? grant_idx : 6'd0;
                alloc_valid <= grant_found;
            end
        end
    end

endmodule

// File: tb/tb_free_list.sv
// ----------------------------------------------------------------------------
// tb_free_list
//
// Self-checking bench for free_list. It uses a non-default PHYS_REGS, so that
// free_phys values at or above PHYS_REGS can occur. A bitmask reference model
// works out the expected grant when each stimulus cycle is driven and pushes
// it onto exp_q. The entry is popped and compared just after the clock edge
// that produces it.
// ----------------------------------------------------------------------------
module tb_free_list;

    localparam int P = 48;
    localparam int W = 7;   // {valid, phys}

    logic       clk;
    logic       reset;
    logic       alloc_en;
    logic [5:0] alloc_phys;
    logic       alloc_valid;
    logic       free_en;
    logic [5:0] free_phys;

    logic [W-1:0] exp_q[$];
    logic [P-1:0] m_mask;
    logic [5:0]   m_phys;
    logic         m_valid;

    int n_vec;
    int n_err;

    free_list #(.PHYS_REGS(P)) dut (
        .clk         (clk),
        .reset       (reset),
        .alloc_en    (alloc_en),
        .alloc_phys  (alloc_phys),
        .alloc_valid (alloc_valid),
        .free_en     (free_en),
        .free_phys   (free_phys)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_step(input logic a_en, input logic f_en, input logic [5:0] f_phys);
        logic   found;
        int     idx;
        found = 1'b0;
        idx   = 0;
        if (a_en) begin
            for (int i = 0; i < P; i++) begin
                if (!found && m_mask[i]) begin
                    found = 1'b1;
                    idx   = i;
                end
            end
            if (found) begin
                m_mask[idx] = 1'b0;
                m_phys      = 6'(idx);
                m_valid     = 1'b1;
            end else begin
                m_phys  = 6'd0;
                m_valid = 1'b0;
            end
        end
        if (f_en && (int'(f_phys) < P)) m_mask[f_phys] = 1'b1;
    endtask

    // ---------------- drivers ----------------
    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        alloc_en  = 1'b1;    // must be ignored during reset
        free_en   = 1'b1;
        free_phys = 6'd3;
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b0;
        alloc_en  = 1'b0;
        free_en   = 1'b0;
        free_phys = 6'd0;
        m_mask  = '1;
        m_phys  = 6'd0;
        m_valid = 1'b0;
        exp_q.delete();
        check("rst_valid", 64'(alloc_valid), 64'd0);
        check("rst_phys", 64'(alloc_phys), 64'd0);
        check("rst_mask", 64'(dut.free_mask), 64'({P{1'b1}}));
    endtask

    // One stimulus cycle: drive at negedge, predict, then compare 1 time unit
    // after the active edge.
    task automatic drive_cycle(input logic a_en, input logic f_en, input logic [5:0] f_phys);
        logic [W-1:0] exp;
        @(negedge clk);
        alloc_en  = a_en;
        free_en   = f_en;
        free_phys = f_phys;
        model_step(a_en, f_en, f_phys);
        exp_q.push_back({m_valid, m_phys});
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        check("grant", 64'({alloc_valid, alloc_phys}), 64'(exp));
        check("mask", 64'(dut.free_mask), 64'(m_mask));
        check("alloc_cnt", 64'(P - $countones(dut.free_mask)), 64'(P - $countones(m_mask)));
        alloc_en  = 1'b0;
        free_en   = 1'b0;
        free_phys = 6'd0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b1;
        alloc_en  = 1'b0;
        free_en   = 1'b0;
        free_phys = 6'd0;
        m_mask    = '1;
        m_phys    = 6'd0;
        m_valid   = 1'b0;

        // 1: alloc pulses, grants 0..9, outputs hold while idle
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b1, 1'b0, 6'd0);
            check("t1_phys", 64'(alloc_phys), 64'(i));
            check("t1_valid", 64'(alloc_valid), 64'd1);
            drive_cycle(1'b0, 1'b0, 6'd0);
            check("t1_hold", 64'(alloc_phys), 64'(i));
        end

        // 2: free 0..4 with no alloc, outputs stay at 9; then regrant 0..4
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b0, 1'b1, 6'(i));
            check("t2_hold", 64'({alloc_valid, alloc_phys}), 64'({1'b1, 6'd9}));
        end
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 1'b0, 6'd0);
            check("t2_regrant", 64'(alloc_phys), 64'(i));
        end

        // 3: exhaust the list, then one more request fails
        do_reset();
        for (int i = 0; i < P; i++) begin
            drive_cycle(1'b1, 1'b0, 6'd0);
            check("t3_phys", 64'(alloc_phys), 64'(i));
        end
        drive_cycle(1'b1, 1'b0, 6'd0);
        check("t3_empty", 64'({alloc_valid, alloc_phys}), 64'd0);
        check("t3_mask0", 64'(dut.free_mask), 64'd0);
        // out-of-range free must be ignored
        drive_cycle(1'b0, 1'b1, 6'(P + 2));
        check("t3_oor", 64'(dut.free_mask), 64'd0);
        // empty list: alloc with simultaneous free still fails
        drive_cycle(1'b1, 1'b1, 6'd7);
        check("t3_simul_fail", 64'(alloc_valid), 64'd0);
        check("t3_simul_bit", 64'(dut.free_mask[7]), 64'd1);

        // 4: alloc 0..4, free 2 then 4, alloc -> 2
        do_reset();
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b0, 6'd0);
        drive_cycle(1'b0, 1'b1, 6'd2);
        drive_cycle(1'b0, 1'b1, 6'd4);
        drive_cycle(1'b1, 1'b0, 6'd0);
        check("t4_phys", 64'({alloc_valid, alloc_phys}), 64'({1'b1, 6'd2}));

        // 5: allocate P-2, then alloc together with free 5
        do_reset();
        for (int i = 0; i < P - 2; i++) drive_cycle(1'b1, 1'b0, 6'd0);
        drive_cycle(1'b1, 1'b1, 6'd5);
        check("t5_phys", 64'({alloc_valid, alloc_phys}), 64'({1'b1, 6'(P - 2)}));
        check("t5_bit5", 64'(dut.free_mask[5]), 64'd1);
        check("t5_cnt", 64'(P - $countones(dut.free_mask)), 64'(P - 2));

        // 6: free of the index being granted, the free wins
        do_reset();
        drive_cycle(1'b1, 1'b1, 6'd0);
        check("t6_phys", 64'({alloc_valid, alloc_phys}), 64'({1'b1, 6'd0}));
        check("t6_bit0", 64'(dut.free_mask[0]), 64'd1);

        // 7: random traffic against the model
        do_reset();
        for (int n = 0; n < 200; n++) begin
            drive_cycle(($urandom_range(0, 99) < 40),
                        ($urandom_range(0, 99) < 30),
                        6'($urandom_range(0, 63)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
